// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell, LSB-first, registered carry.
// Optional subtract mode and signed-overflow flag via `define SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADDER_SUB_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   sum_sh;
  logic [WIDTH-1:0]   sum_q;
  logic               carry;
  logic               cout_q;
  logic [CNT_W-1:0]   cnt;

  logic               bit_s;
  logic               bit_c;
  logic [WIDTH:0]     sum_cat;
  logic               last;
  logic [WIDTH-1:0]   b_load;
  logic               carry_load;

  always_comb begin
    bit_s   = a_sh[0] ^ b_sh[0] ^ carry;
    bit_c   = (a_sh[0] & b_sh[0]) | ((a_sh[0] ^ b_sh[0]) & carry);
    // Concatenate then drop the LSB so the shift also works for WIDTH=1.
    sum_cat = {bit_s, sum_sh};
    last    = (cnt == CNT_W'(WIDTH - 1));
`ifdef SERIAL_ADDER_SUB_EN
    b_load     = sub ? ~b : b;
    carry_load = sub | cin;
`else
    b_load     = b;
    carry_load = cin;
`endif
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == SHIFT);
  assign out_valid = (state == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

`ifdef SERIAL_ADDER_SUB_EN
  logic ovf_q;
  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      cnt    <= '0;
`ifdef SERIAL_ADDER_SUB_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh   <= a;
            b_sh   <= b_load;
            carry  <= carry_load;
            cnt    <= '0;
            sum_sh <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          sum_sh <= sum_cat[WIDTH:1];
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= bit_c;
          cnt    <= cnt + 1'b1;
          if (last) begin
            // Result registers are captured here so they survive the next load.
            sum_q  <= sum_cat[WIDTH:1];
            cout_q <= bit_c;
`ifdef SERIAL_ADDER_SUB_EN
            ovf_q  <= carry ^ bit_c;
`endif
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8) against an arithmetic reference model.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       sub;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       busy;
  logic       ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef SERIAL_ADDER_SUB_EN
    ,
    .ovf       (ovf)
`endif
  );

`ifndef SERIAL_ADDER_SUB_EN
  assign ovf = 1'b0;
`endif

  // Reference: {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                       input logic mc, input logic ms);
    int unsigned u;
    int          sa;
    int          sb;
    int          sr;
    logic [9:0]  r;
    sa = $signed(ma);
    sb = $signed(mb);
    if (ms) begin
      u  = int'(ma) + (int'(~mb) & 255) + 1;
      sr = sa - sb;
    end else begin
      u  = int'(ma) + int'(mb) + int'(mc);
      sr = sa + sb + int'(mc);
    end
    r[7:0] = u[7:0];
    r[8]   = u[8];
    r[9]   = (sr > 127) || (sr < -128);
    return r;
  endfunction

  // Issues one operation, waits for the result, holds out_ready low for 'hold' DONE cycles.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                        input logic ts, input int hold,
                        output logic [7:0] rs, output logic rc, output logic ro,
                        output int lat, output int busyc, output bit tmo);
    int n;
    tmo = 0; lat = 0; busyc = 0; n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) tmo = 1;
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 100) begin
      busyc += int'(busy);
      @(negedge clk);
      lat++;
    end
    if (!out_valid) tmo = 1;
    repeat (hold) @(negedge clk);
    rs = sum; rc = cout; ro = ovf;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (sum !== 8'h00) begin bad++; $display("FAIL reset_sum: got %h want 00", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout: got %b want 0", cout); end
  endtask

  task automatic test_basic();
    logic [7:0] s; logic c, o; int lat, bc; bit tmo;
    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 0, s, c, o, lat, bc, tmo);
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL basic_timeout: got %b want 0", tmo); end
    total++; if (s !== 8'h10) begin bad++; $display("FAIL basic_sum: got %h want 10", s); end
    total++; if (c !== 1'b0) begin bad++; $display("FAIL basic_cout: got %b want 0", c); end
    total++; if (lat != 8) begin bad++; $display("FAIL basic_latency: got %0d want 8", lat); end
    total++; if (bc != 8) begin bad++; $display("FAIL basic_busy_cycles: got %0d want 8", bc); end
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++;
      $display("FAIL basic_return_idle: got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); end
    total++; if (sum !== 8'h10) begin bad++; $display("FAIL basic_sum_retained: got %h want 10", sum); end
  endtask

  task automatic test_carry();
    logic [7:0] s; logic c, o; int lat, bc; bit tmo;
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, s, c, o, lat, bc, tmo);
    total++; if (tmo || s !== 8'h00 || c !== 1'b1) begin bad++;
      $display("FAIL carry_ff_01: got sum=%h cout=%b tmo=%b want sum=00 cout=1", s, c, tmo); end
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 0, s, c, o, lat, bc, tmo);
    total++; if (tmo || s !== 8'hFF || c !== 1'b1) begin bad++;
      $display("FAIL carry_ff_ff_1: got sum=%h cout=%b tmo=%b want sum=ff cout=1", s, c, tmo); end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    a = 8'h3C; b = 8'h5A; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_timeout: got %b want 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_valid !== 1'b1 || sum !== 8'h97 || cout !== 1'b0 || in_ready !== 1'b0) begin bad++;
        $display("FAIL bp_hold_%0d: got ov=%b sum=%h cout=%b ir=%b want ov=1 sum=97 cout=0 ir=0",
                 i, out_valid, sum, cout, in_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++;
      $display("FAIL bp_release: got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    int n;
    time t, prev;
    logic [9:0] e;
    logic [7:0] ta, tb_;
    logic tc;
    prev = 0;
    out_ready = 1'b1;
    sub = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (!in_ready && n < 20) begin @(negedge clk); n++; end
      ta = 8'($urandom); tb_ = 8'($urandom); tc = 1'($urandom);
      a = ta; b = tb_; cin = tc; in_valid = 1'b1;
      e = model(ta, tb_, tc, 1'b0);
      t = $time;
      if (i > 0) begin
        total++; if ((t - prev) != 100) begin bad++;
          $display("FAIL b2b_interval_%0d: got %0t want 100", i, t - prev); end
      end
      prev = t;
      @(negedge clk);
      n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      total++; if (out_valid !== 1'b1 || sum !== e[7:0] || cout !== e[8]) begin bad++;
        $display("FAIL b2b_result_%0d: got ov=%b sum=%h cout=%b want ov=1 sum=%h cout=%b",
                 i, out_valid, sum, cout, e[7:0], e[8]); end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] s; logic c, o; int lat, bc; bit tmo; bit seen;
    @(negedge clk);
    a = 8'h77; b = 8'h22; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== 8'h00) begin bad++;
      $display("FAIL midrst_state: got ir=%b ov=%b busy=%b sum=%h want ir=1 ov=0 busy=0 sum=00",
               in_ready, out_valid, busy, sum); end
    seen = 0;
    repeat (12) begin @(negedge clk); if (out_valid) seen = 1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_no_result: got %b want 0", seen); end
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 0, s, c, o, lat, bc, tmo);
    total++; if (tmo || s !== 8'h46 || c !== 1'b0) begin bad++;
      $display("FAIL midrst_next_op: got sum=%h cout=%b tmo=%b want sum=46 cout=0", s, c, tmo); end
  endtask

  task automatic test_ignored_input();
    int n;
    @(negedge clk);
    a = 8'h0F; b = 8'h01; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    total++; if (out_valid !== 1'b1 || sum !== 8'h10 || cout !== 1'b0) begin bad++;
      $display("FAIL ignored_result: got ov=%b sum=%h cout=%b want ov=1 sum=10 cout=0", out_valid, sum, cout); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++;
      $display("FAIL ignored_no_phantom: got ir=%b busy=%b want ir=1 busy=0", in_ready, busy); end
  endtask

  task automatic test_random();
    logic [7:0] s, ta, tb_; logic c, o, tc, ts; int lat, bc; bit tmo; logic [9:0] e;
    for (int i = 0; i < 25; i++) begin
      ta = 8'($urandom); tb_ = 8'($urandom); tc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      ts = 1'($urandom);
`else
      ts = 1'b0;
`endif
      e = model(ta, tb_, tc, ts);
      run_op(ta, tb_, tc, ts, int'($urandom_range(0, 3)), s, c, o, lat, bc, tmo);
      total++; if (tmo || lat != 8 || s !== e[7:0] || c !== e[8]) begin bad++;
        $display("FAIL random_%0d: a=%h b=%h cin=%b sub=%b got sum=%h cout=%b lat=%0d want sum=%h cout=%b lat=8",
                 i, ta, tb_, tc, ts, s, c, lat, e[7:0], e[8]); end
`ifdef SERIAL_ADDER_SUB_EN
      total++; if (o !== e[9]) begin bad++;
        $display("FAIL random_ovf_%0d: got %b want %b", i, o, e[9]); end
`endif
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    logic [7:0] s; logic c, o; int lat, bc; bit tmo;
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 0, s, c, o, lat, bc, tmo);
    total++; if (tmo || s !== 8'hFE || c !== 1'b0 || o !== 1'b0) begin bad++;
      $display("FAIL sub_05_07: got sum=%h cout=%b ovf=%b want sum=fe cout=0 ovf=0", s, c, o); end
    run_op(8'h80, 8'h01, 1'b0, 1'b1, 0, s, c, o, lat, bc, tmo);
    total++; if (tmo || s !== 8'h7F || c !== 1'b1 || o !== 1'b1) begin bad++;
      $display("FAIL sub_80_01: got sum=%h cout=%b ovf=%b want sum=7f cout=1 ovf=1", s, c, o); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_ignored_input();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder sequencer. It accepts two WIDTH-bit operands through a valid/ready handshake and feeds them LSB-first through a single full-adder bit cell, one bit per clock, with a registered carry.
- It assembles the WIDTH-bit sum and the final carry-out, then presents them through an output valid/ready handshake.
- It is the area-lean alternative to the ripple-carry path: one full-adder cell plus control instead of WIDTH cells.

Parameters:
- WIDTH, 8: operand and sum width in bits; legal range is 1 to 64.
- CNT_W, $clog2(WIDTH+1): internal local parameter for the bit counter width; not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a, b, cin are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry into bit 0.
- out_valid  output  1  sum and cout are valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result bits.
- cout  output  1  carry out of bit WIDTH-1.
- busy  output  1  high while in SHIFT.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - rst is synchronous and active-high. When sampled high, the block goes to IDLE.
  - Reset values: in_ready=1, out_valid=0, busy=0, sum=0, cout=0, carry register=0, counter=0, shift registers=0.
  - rst has priority over every other event, including mid-SHIFT and DONE. Any in-flight operation is discarded, no result is produced, and out_valid stays 0.
- States: IDLE, SHIFT, DONE, held in a 2-bit state register. The unused encoding goes to IDLE.
- IDLE:
  - in_ready=1, busy=0, out_valid=0.
  - On in_valid & in_ready: load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, sum_sh<=0, then go to SHIFT.
- SHIFT:
  - in_ready=0, busy=1.
  - Each cycle compute the bit cell from a_sh[0], b_sh[0], carry:
    - s = a_sh[0] ^ b_sh[0] ^ carry
    - c = (a_sh[0] & b_sh[0]) | ((a_sh[0] ^ b_sh[0]) & carry)
  - Update: sum_sh <= {s, sum_sh[WIDTH-1:1]}; a_sh and b_sh shift right by 1 with zero fill; carry <= c; cnt <= cnt+1.
  - When cnt == WIDTH-1 on the current edge, go to DONE.
  - SHIFT therefore takes exactly WIDTH cycles.
- DONE:
  - out_valid=1, sum=sum_sh, cout=carry. These are held stable until accepted.
  - in_ready=0, busy=0.
  - On out_valid & out_ready: go to IDLE. The sum and cout registers keep their last value; only out_valid falls.
- Latency:
  - Input handshake on edge k gives out_valid high after edge k+WIDTH.
  - Minimum issue interval is WIDTH+2 cycles: accept, WIDTH shift cycles, one DONE cycle with out_ready=1.
- Handshake rules:
  - in_ready is not combinationally dependent on in_valid.
  - out_valid is not dependent on out_ready.
  - in_valid asserted during SHIFT or DONE is ignored; the operands must be held by the source until accepted.
  - No input acceptance in the same cycle as the output handshake. The block returns to IDLE first.
- WIDTH=1: SHIFT lasts one cycle, giving a single full-add.
- Overflow: cout is the unsigned carry. No signed-overflow flag unless the optional feature below is compiled in.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled at the input handshake and stored.
  - When stored sub=1: b_sh loads ~b and carry loads 1, ignoring cin, so the result is a-b in two's complement. cout=1 means no borrow (a>=b unsigned).
  - Adds output ovf (1 bit, reset 0), valid in DONE: signed overflow = carry into MSB XOR carry out of MSB. This needs the MSB carry-in captured on the last SHIFT cycle.
- Not defined: no sub or ovf ports; add-only behaviour as above.

Test Plan (WIDTH=8):
- Basic add: a=0x0F, b=0x01, cin=0, accepted at edge k -> out_valid high after edge k+8, sum=0x10, cout=0; busy high for exactly 8 cycles.
- Carry chain: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Backpressure: out_ready held 0 for 5 cycles in DONE -> out_valid, sum, cout stable; in_ready=0 throughout; IDLE one cycle after out_ready=1. Back-to-back operation with out_ready tied 1 -> issue interval of 10 cycles.
- Reset mid-operation: rst=1 on the 4th SHIFT cycle -> next cycle in_ready=1, out_valid=0, busy=0, sum=0; a new operand pair 0x12+0x34 -> sum=0x46, cout=0.
- Ignored input: in_valid pulsed with a=0xAA during SHIFT -> no effect on the in-flight result (0x0F+0x01 still gives 0x10).
- With SERIAL_ADDER_SUB_EN: sub=1, a=0x05, b=0x07 -> sum=0xFE, cout=0, ovf=0. Then sub=1, a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
